// File: rtl/phase_step_sequencer_pkg.sv
// Shared widths and FSM encoding for the phase-step sequencer.
package phase_step_sequencer_pkg;

  localparam int unsigned PHASE_W = 30;
  localparam int unsigned COUNT_W = 8;
  localparam int unsigned STEPS_W = 16;
  localparam int unsigned HOLD_W  = PHASE_W + 1;
  localparam int unsigned CMD_W   = PHASE_W + COUNT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    GAP  = 2'd3
  } state_t;

endpackage

// File: rtl/phase_step_sequencer_if.sv
// Command handshake between the host register block and the sequencer.
interface phase_step_sequencer_if;
  import phase_step_sequencer_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [PHASE_W-1:0] cmd_step;
  logic [COUNT_W-1:0] cmd_count;

  modport master (output cmd_valid, output cmd_step, output cmd_count, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_step, input cmd_count, output cmd_ready);

endinterface

// File: rtl/phase_step_sequencer_cmd_fifo.sv
// First-word-fall-through command queue with registered full/empty flags.
module cmd_fifo #(
  parameter int unsigned WIDTH = 38,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  // A push into a full queue is legal only when the head leaves the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop)
      count_next = count + (AW+1)'(1);
    else if (!do_push && do_pop)
      count_next = count - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/phase_step_sequencer.sv
// Drives the divider phase_increment with hold-then-release steps from a command queue.
module phase_step_sequencer
  import phase_step_sequencer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned HOLD_MARGIN = 4,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  phase_step_sequencer_if.slave  cmd,
  input  logic                   flush,
  input  logic [PHASE_W-1:0]     clk_divider_modulus,
  output logic [PHASE_W-1:0]     phase_increment,
  output logic                   busy,
  output logic [STEPS_W-1:0]     steps_done,
  output logic                   step_error
);

  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  state_t             state, next_state;
  logic               accept, cmd_legal, cmd_too_big, push;
  logic               fifo_full, fifo_empty;
  logic [CMD_W-1:0]   fifo_dout;
  logic [PHASE_W-1:0] cur_step;
  logic [COUNT_W-1:0] cur_count;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               hold_last, gap_last;
  logic               pop, load_step, end_step, enter_gap;

  assign cmd.cmd_ready = !fifo_full;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready && !flush;
  assign cmd_legal     = (cmd.cmd_step != '0) && (cmd.cmd_count != '0);
  assign cmd_too_big   = cmd.cmd_step > clk_divider_modulus;
  assign push          = accept && cmd_legal && !cmd_too_big;
  assign hold_last     = (hold_cnt == HOLD_W'(1));
  assign gap_last      = (gap_cnt == GAP_W'(1));
  assign busy          = (state != IDLE) || !fifo_empty;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .din   ({cmd.cmd_step, cmd.cmd_count}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (!fifo_empty && !flush) next_state = LOAD;
      LOAD: next_state = flush ? GAP : HOLD;
      HOLD: if (flush || hold_last) next_state = GAP;
      GAP:  if (gap_last) next_state = (cur_count != '0 && !flush) ? LOAD : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A flush always wins over a step that would otherwise complete this cycle.
  always_comb begin
    pop       = (state == IDLE) && !fifo_empty && !flush;
    load_step = (state == LOAD) && !flush;
    end_step  = (state == HOLD) && hold_last && !flush;
    enter_gap = ((state == LOAD) && flush) || ((state == HOLD) && (flush || hold_last));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_increment <= '0;
      steps_done      <= '0;
      step_error      <= 1'b0;
      cur_step        <= '0;
      cur_count       <= '0;
      hold_cnt        <= '0;
      gap_cnt         <= '0;
    end else begin
      if (accept && cmd_legal && cmd_too_big) step_error <= 1'b1;
      if (pop) {cur_step, cur_count} <= fifo_dout;

      if (load_step) begin
        phase_increment <= cur_step;
        hold_cnt <= HOLD_W'(clk_divider_modulus) + HOLD_W'(1) + HOLD_W'(HOLD_MARGIN);
      end else if (state == HOLD) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end

      if (enter_gap) begin
        phase_increment <= '0;
        gap_cnt         <= GAP_W'(GAP_CYCLES);
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end

      if (end_step) begin
        steps_done <= steps_done + STEPS_W'(1);
        cur_count  <= cur_count - COUNT_W'(1);
      end
      if (flush) cur_count <= '0;
    end
  end

endmodule

// File: tb/tb_phase_step_sequencer.sv
// Directed self-checking bench for phase_step_sequencer with default parameters.
module tb_phase_step_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [29:0] modulus;
  logic [29:0] phase_increment;
  logic        busy;
  logic [15:0] steps_done;
  logic        step_error;

  int total = 0;
  int bad   = 0;
  int exp_steps = 0;

  logic [29:0] rec [$];
  logic [29:0] prev_phase = '0;
  logic        rec_en = 1'b0;

  phase_step_sequencer_if cmd_if ();

  phase_step_sequencer #(
    .FIFO_DEPTH  (4),
    .HOLD_MARGIN (4),
    .GAP_CYCLES  (4)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cmd                 (cmd_if),
    .flush               (flush),
    .clk_divider_modulus (modulus),
    .phase_increment     (phase_increment),
    .busy                (busy),
    .steps_done          (steps_done),
    .step_error          (step_error)
  );

  always #5 clk = ~clk;

  // Records each distinct nonzero step value in the order it appears.
  always @(negedge clk) begin
    if (rec_en && phase_increment != '0 && phase_increment != prev_phase)
      rec.push_back(phase_increment);
    prev_phase = phase_increment;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one command, waits for ready (bounded), returns 1ns after the accepting edge.
  task automatic send(input logic [29:0] s, input logic [7:0] c, output int stalls);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_step  = s;
    cmd_if.cmd_count = c;
    stalls = 0;
    while (!cmd_if.cmd_ready && stalls < 500) begin
      tick();
      stalls++;
    end
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    modulus = 30'd10;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_step  = '0;
    cmd_if.cmd_count = '0;
    repeat (3) tick();
    total++; if (phase_increment !== 30'd0) begin bad++; $display("FAIL reset_phase got=%0d exp=0", phase_increment); end
    total++; if (steps_done !== 16'd0) begin bad++; $display("FAIL reset_steps got=%0d exp=0", steps_done); end
    total++; if (step_error !== 1'b0) begin bad++; $display("FAIL reset_error got=%0b exp=0", step_error); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (cmd_if.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", cmd_if.cmd_ready); end
    rst = 1'b0;
    repeat (2) tick();
    total++; if (busy !== 1'b0 || phase_increment !== 30'd0) begin bad++; $display("FAIL post_reset busy=%0b phase=%0d exp busy=0 phase=0", busy, phase_increment); end
  endtask

  task automatic test_single_step();
    int st;
    logic [29:0] exp;
    modulus = 30'd10;
    send(30'd3, 8'd1, st);
    for (int i = 0; i < 20; i++) begin
      exp = (i >= 2 && i < 17) ? 30'd3 : 30'd0;
      total++; if (phase_increment !== exp) begin bad++; $display("FAIL single_phase i=%0d got=%0d exp=%0d", i, phase_increment, exp); end
      if (i < 19) tick();
    end
    repeat (4) tick();
    exp_steps = exp_steps + 1;
    total++; if (steps_done !== 16'(exp_steps)) begin bad++; $display("FAIL single_steps got=%0d exp=%0d", steps_done, exp_steps); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_repeat();
    int st, k;
    logic [29:0] exp;
    logic        exp_busy;
    logic [15:0] exp_sd;
    modulus = 30'd10;
    send(30'd2, 8'd3, st);
    for (int i = 0; i < 66; i++) begin
      k = i - 2;
      exp = (i >= 2 && k < 60 && (k % 20) < 15) ? 30'd2 : 30'd0;
      exp_busy = (i < 61);
      exp_sd = 16'(exp_steps + (i >= 17 ? 1 : 0) + (i >= 37 ? 1 : 0) + (i >= 57 ? 1 : 0));
      total++; if (phase_increment !== exp) begin bad++; $display("FAIL repeat_phase i=%0d got=%0d exp=%0d", i, phase_increment, exp); end
      total++; if (busy !== exp_busy) begin bad++; $display("FAIL repeat_busy i=%0d got=%0b exp=%0b", i, busy, exp_busy); end
      total++; if (steps_done !== exp_sd) begin bad++; $display("FAIL repeat_steps i=%0d got=%0d exp=%0d", i, steps_done, exp_sd); end
      tick();
    end
    exp_steps = exp_steps + 3;
  endtask

  task automatic test_backpressure();
    int st, n;
    logic [29:0] exp_seq [7];
    exp_seq = '{30'd9, 30'd1, 30'd2, 30'd3, 30'd4, 30'd5, 30'd6};
    modulus = 30'd10;
    rec.delete();
    rec_en = 1'b1;
    send(30'd9, 8'd1, st);
    repeat (2) tick();
    for (int i = 0; i < 6; i++) begin
      send(30'(i + 1), 8'd1, st);
      total++; if (st >= 500) begin bad++; $display("FAIL bp_timeout cmd=%0d stalls=%0d exp<500", i, st); end
      if (i < 4) begin
        total++; if (st !== 0) begin bad++; $display("FAIL bp_nostall cmd=%0d stalls=%0d exp=0", i, st); end
      end
      if (i == 3) begin
        total++; if (cmd_if.cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_low got=%0b exp=0", cmd_if.cmd_ready); end
      end
      if (i == 4) begin
        total++; if (st == 0) begin bad++; $display("FAIL bp_stall cmd=4 stalls=%0d exp>0", st); end
      end
    end
    n = 0;
    while (busy && n < 1000) begin tick(); n++; end
    repeat (2) tick();
    rec_en = 1'b0;
    total++; if (n >= 1000) begin bad++; $display("FAIL bp_drain cycles=%0d exp<1000", n); end
    total++; if (rec.size() !== 7) begin bad++; $display("FAIL bp_count got=%0d exp=7", rec.size()); end
    for (int i = 0; i < 7; i++) begin
      if (i < rec.size()) begin
        total++; if (rec[i] !== exp_seq[i]) begin bad++; $display("FAIL bp_order idx=%0d got=%0d exp=%0d", i, rec[i], exp_seq[i]); end
      end
    end
    exp_steps = exp_steps + 7;
    total++; if (steps_done !== 16'(exp_steps)) begin bad++; $display("FAIL bp_steps got=%0d exp=%0d", steps_done, exp_steps); end
  endtask

  task automatic test_illegal();
    int st;
    logic [29:0] exp;
    modulus = 30'd10;
    send(30'd0, 8'd5, st);
    for (int i = 0; i < 8; i++) begin
      total++; if (phase_increment !== 30'd0 || busy !== 1'b0) begin bad++; $display("FAIL zero_step i=%0d phase=%0d busy=%0b exp phase=0 busy=0", i, phase_increment, busy); end
      tick();
    end
    send(30'd4, 8'd0, st);
    for (int i = 0; i < 8; i++) begin
      total++; if (phase_increment !== 30'd0 || busy !== 1'b0) begin bad++; $display("FAIL zero_count i=%0d phase=%0d busy=%0b exp phase=0 busy=0", i, phase_increment, busy); end
      tick();
    end
    total++; if (step_error !== 1'b0) begin bad++; $display("FAIL error_clear got=%0b exp=0", step_error); end
    send(30'd11, 8'd1, st);
    for (int i = 0; i < 8; i++) begin
      total++; if (phase_increment !== 30'd0 || busy !== 1'b0 || step_error !== 1'b1) begin bad++; $display("FAIL too_big i=%0d phase=%0d busy=%0b err=%0b exp 0 0 1", i, phase_increment, busy, step_error); end
      tick();
    end
    send(30'd10, 8'd1, st);
    for (int i = 0; i < 24; i++) begin
      exp = (i >= 2 && i < 17) ? 30'd10 : 30'd0;
      total++; if (phase_increment !== exp) begin bad++; $display("FAIL edge_step i=%0d got=%0d exp=%0d", i, phase_increment, exp); end
      tick();
    end
    exp_steps = exp_steps + 1;
    total++; if (step_error !== 1'b1) begin bad++; $display("FAIL error_sticky got=%0b exp=1", step_error); end
    total++; if (steps_done !== 16'(exp_steps)) begin bad++; $display("FAIL illegal_steps got=%0d exp=%0d", steps_done, exp_steps); end
  endtask

  task automatic test_flush();
    int st;
    logic exp_busy;
    logic quiet;
    modulus = 30'd10;
    send(30'd7, 8'd1, st);
    send(30'd1, 8'd1, st);
    send(30'd2, 8'd1, st);
    repeat (4) tick();
    total++; if (phase_increment !== 30'd7) begin bad++; $display("FAIL flush_pre_phase got=%0d exp=7", phase_increment); end
    flush = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_step  = 30'd3;
    cmd_if.cmd_count = 8'd1;
    total++; if (cmd_if.cmd_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%0b exp=1", cmd_if.cmd_ready); end
    tick();
    flush = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    total++; if (phase_increment !== 30'd0) begin bad++; $display("FAIL flush_phase got=%0d exp=0", phase_increment); end
    total++; if (steps_done !== 16'(exp_steps)) begin bad++; $display("FAIL flush_steps got=%0d exp=%0d", steps_done, exp_steps); end
    for (int k = 8; k <= 11; k++) begin
      tick();
      exp_busy = (k < 11);
      total++; if (busy !== exp_busy) begin bad++; $display("FAIL flush_gap k=%0d busy=%0b exp=%0b", k, busy, exp_busy); end
    end
    quiet = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (phase_increment !== 30'd0 || busy !== 1'b0) quiet = 1'b0;
    end
    total++; if (quiet !== 1'b1) begin bad++; $display("FAIL flush_quiet got=%0b exp=1", quiet); end
    total++; if (steps_done !== 16'(exp_steps)) begin bad++; $display("FAIL flush_steps_end got=%0d exp=%0d", steps_done, exp_steps); end
  endtask

  task automatic test_async_reset();
    int st;
    logic quiet;
    modulus = 30'd10;
    send(30'd6, 8'd2, st);
    repeat (5) tick();
    total++; if (phase_increment !== 30'd6) begin bad++; $display("FAIL ar_pre_phase got=%0d exp=6", phase_increment); end
    total++; if (steps_done !== 16'(exp_steps)) begin bad++; $display("FAIL ar_pre_steps got=%0d exp=%0d", steps_done, exp_steps); end
    #3;
    rst = 1'b1;
    #1;
    exp_steps = 0;
    total++; if (phase_increment !== 30'd0) begin bad++; $display("FAIL ar_phase got=%0d exp=0", phase_increment); end
    total++; if (cmd_if.cmd_ready !== 1'b1) begin bad++; $display("FAIL ar_ready got=%0b exp=1", cmd_if.cmd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_busy got=%0b exp=0", busy); end
    total++; if (steps_done !== 16'd0) begin bad++; $display("FAIL ar_steps got=%0d exp=0", steps_done); end
    tick();
    tick();
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (phase_increment !== 30'd0 || busy !== 1'b0 || steps_done !== 16'd0 || cmd_if.cmd_ready !== 1'b1) quiet = 1'b0;
    end
    total++; if (quiet !== 1'b1) begin bad++; $display("FAIL ar_after got=%0b exp=1", quiet); end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_repeat();
    test_backpressure();
    test_illegal();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
